// File: rtl/chip8_bus_master_if.sv
// Chip8 register/memory slave bus: chipselect/write/address/writedata
// driven by the initiator, readdata (slave data_out) returned by the slave.
interface chip8_bus_master_if;
  logic        chipselect;
  logic        write;
  logic [17:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect,
    output write,
    output address,
    output writedata,
    input  readdata
  );

  modport slave (
    input  chipselect,
    input  write,
    input  address,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/chip8_bus_master.sv
// Chip8 bus master: turns a command stream (single register read/write,
// burst byte write/read of program memory) into Chip8 slave bus cycles.
// Optional build macro CHIP8_BM_READBACK_EN: every burst write beat is read
// back and compared; a mismatch sets the sticky verify_err flag.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command
// ISSUE  | driving a bus beat (single write, burst write beats, read cs)
// WAIT   | counting READ_LATENCY after a read chipselect, then sample
// RESP   | holding read data on rsp_* until the consumer accepts it
module chip8_bus_master #(
  parameter int READ_LATENCY = 1,
  parameter int LEN_W        = 12,
  parameter int MEM_BASE_BIT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic                cmd_burst,
  input  logic [17:0]         cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [31:0]         cmd_wdata,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [7:0]          wr_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic                rsp_last,
  chip8_bus_master_if.master  bus,
  output logic                busy,
  output logic                verify_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t            state;
  logic              wr_q;
  logic              burst_q;
  logic [17:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [11:0]       offset;
  logic [LEN_W-1:0]  beats;
  logic [1:0]        lat_cnt;
  logic              verify_err_q;
`ifdef CHIP8_BM_READBACK_EN
  logic              rb_phase;
  logic [7:0]        rb_byte;
`endif

  // Memory window address: upper bits of the command address with the
  // window-select bit forced, low 12 bits from the running offset.
  function automatic logic [17:0] mem_addr(input logic [17:0] base, input logic [11:0] off);
    logic [17:0] t;
    t = base;
    t[MEM_BASE_BIT] = 1'b1;
    return {t[17:12], off};
  endfunction

  // Whole controller: state, beat/offset bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cmd_ready      <= 1'b1;
      wr_ready       <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_last       <= 1'b0;
      busy           <= 1'b0;
      bus.chipselect <= 1'b0;
      bus.write      <= 1'b0;
      bus.address    <= '0;
      bus.writedata  <= '0;
      wr_q           <= 1'b0;
      burst_q        <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      offset         <= '0;
      beats          <= '0;
      lat_cnt        <= '0;
      verify_err_q   <= 1'b0;
`ifdef CHIP8_BM_READBACK_EN
      rb_phase       <= 1'b0;
      rb_byte        <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          bus.chipselect <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            wr_q      <= cmd_write;
            burst_q   <= cmd_burst;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            offset    <= cmd_addr[11:0];
            if (cmd_burst)
              beats <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
            else
              beats <= LEN_W'(1);
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
            if (cmd_write && !cmd_burst) begin
              bus.chipselect <= 1'b1;
              bus.write      <= 1'b1;
              bus.address    <= cmd_addr;
              bus.writedata  <= cmd_wdata;
            end else if (cmd_write) begin
              // burst write waits for the first byte
              wr_ready <= 1'b1;
            end else begin
              bus.chipselect <= 1'b1;
              bus.write      <= 1'b0;
              bus.address    <= cmd_burst ? mem_addr(cmd_addr, cmd_addr[11:0]) : cmd_addr;
            end
          end
        end

        ST_ISSUE: begin
          if (!wr_q) begin
            bus.chipselect <= 1'b0;
            lat_cnt        <= 2'(READ_LATENCY - 1);
            state          <= ST_WAIT;
          end else if (!burst_q) begin
            bus.chipselect <= 1'b0;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            state          <= ST_IDLE;
`ifdef CHIP8_BM_READBACK_EN
          end else if (rb_phase) begin
            // write beat is on the bus now; read the same address next
            rb_phase       <= 1'b0;
            bus.chipselect <= 1'b1;
            bus.write      <= 1'b0;
            lat_cnt        <= 2'(READ_LATENCY - 1);
            state          <= ST_WAIT;
`endif
          end else begin
            bus.chipselect <= wr_valid && wr_ready;
            if (wr_valid && wr_ready) begin
              bus.write     <= 1'b1;
              bus.address   <= mem_addr(addr_q, offset);
              bus.writedata <= {24'b0, wr_data};
              offset        <= offset + 12'd1;
              beats         <= beats - LEN_W'(1);
`ifdef CHIP8_BM_READBACK_EN
              wr_ready      <= 1'b0;
              rb_phase      <= 1'b1;
              rb_byte       <= wr_data;
`else
              if (beats == LEN_W'(1)) begin
                wr_ready  <= 1'b0;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
                state     <= ST_IDLE;
              end
`endif
            end
          end
        end

        ST_WAIT: begin
          if (lat_cnt == 2'd0) begin
`ifdef CHIP8_BM_READBACK_EN
            if (wr_q) begin
              if (bus.readdata[7:0] != rb_byte)
                verify_err_q <= 1'b1;
              if (beats == '0) begin
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
                state     <= ST_IDLE;
              end else begin
                wr_ready <= 1'b1;
                state    <= ST_ISSUE;
              end
            end else begin
              rsp_data  <= bus.readdata;
              rsp_valid <= 1'b1;
              rsp_last  <= (beats == LEN_W'(1));
              state     <= ST_RESP;
            end
`else
            rsp_data  <= bus.readdata;
            rsp_valid <= 1'b1;
            rsp_last  <= (beats == LEN_W'(1));
            state     <= ST_RESP;
`endif
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            if (beats > LEN_W'(1)) begin
              beats          <= beats - LEN_W'(1);
              offset         <= offset + 12'd1;
              bus.chipselect <= 1'b1;
              bus.write      <= 1'b0;
              bus.address    <= mem_addr(addr_q, offset + 12'd1);
              state          <= ST_ISSUE;
            end else begin
              beats     <= '0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CHIP8_BM_READBACK_EN
  assign verify_err = verify_err_q;
`else
  assign verify_err = 1'b0;
`endif

endmodule
